modrm_sib_ea_pipe: RTL

//  Pipelined ModR/M + SIB effective-address generator for 16- and 32-bit address sizes.

---
 rtl/x86_addr_pkg.sv | 47 ++++
 rtl/modrm_sib_select.sv | 88 ++++++++
 rtl/modrm_sib_ea_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/x86_addr_pkg.sv
// Shared x86 addressing definitions: ModR/M and SIB layouts, GPR numbering,
// special encodings and displacement sign-extension helpers.
package x86_addr_pkg;

  typedef struct packed {
    logic [1:0] mod;
    logic [2:0] reg_op;
    logic [2:0] rm;
  } modrm_t;

  typedef struct packed {
    logic [1:0] scale;
    logic [2:0] index;
    logic [2:0] base;
  } sib_t;

  localparam logic [2:0] GPR_EAX = 3'd0;
  localparam logic [2:0] GPR_ECX = 3'd1;
  localparam logic [2:0] GPR_EDX = 3'd2;
  localparam logic [2:0] GPR_EBX = 3'd3;
  localparam logic [2:0] GPR_ESP = 3'd4;
  localparam logic [2:0] GPR_EBP = 3'd5;
  localparam logic [2:0] GPR_ESI = 3'd6;
  localparam logic [2:0] GPR_EDI = 3'd7;

  // SIB index field value meaning "no index register"
  localparam logic [2:0] NO_INDEX       = 3'b100;
  // rm (16-bit) / rm or SIB base (32-bit) encodings that mean displacement only under mod 00
  localparam logic [2:0] DISP_ONLY_RM16 = 3'b110;
  localparam logic [2:0] DISP_ONLY_RM32 = 3'b101;
  // rm value that pulls in a SIB byte in 32-bit mode
  localparam logic [2:0] SIB_RM         = 3'b100;

  localparam logic [1:0] MOD_NODISP    = 2'b00;
  localparam logic [1:0] MOD_DISP8     = 2'b01;
  localparam logic [1:0] MOD_DISP_FULL = 2'b10;
  localparam logic [1:0] MOD_REG       = 2'b11;

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/modrm_sib_select.sv
// Combinational operand selection: picks base/index register values, scale,
// extended displacement and the SS-default flag from ModR/M, SIB and the GPR snapshot.
module modrm_sib_select
  import x86_addr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                addr32_i,
  input  logic [1:0]          mod_i,
  input  logic [2:0]          rm_i,
  input  sib_t                sib_i,
  input  logic [31:0]         disp_i,
  input  logic [8*ADDR_W-1:0] gpr_i,
  output logic [ADDR_W-1:0]   base_o,
  output logic [ADDR_W-1:0]   index_o,
  output logic [1:0]          scale_o,
  output logic [ADDR_W-1:0]   disp_o,
  output logic                ss_o
);

  logic [ADDR_W-1:0] lane_s [8];
  logic [31:0]       disp32_s;

  // Split the flat GPR snapshot into per-register lanes
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane_s[k] = gpr_i[k*ADDR_W +: ADDR_W];
    end
  end

  // Decode the addressing form; absent base/index terms contribute zero
  always_comb begin
    base_o   = '0;
    index_o  = '0;
    scale_o  = 2'b00;
    ss_o     = 1'b0;
    case (mod_i)
      MOD_DISP8:     disp32_s = sext8(disp_i[7:0]);
      MOD_DISP_FULL: disp32_s = addr32_i ? disp_i : sext16(disp_i[15:0]);
      default:       disp32_s = 32'h0000_0000;
    endcase

    if (mod_i == MOD_REG) begin
      // register operand: no memory address, ea stays zero
      disp32_s = 32'h0000_0000;
    end else if (!addr32_i) begin
      case (rm_i)
        3'b000: begin base_o = lane_s[GPR_EBX]; index_o = lane_s[GPR_ESI]; end
        3'b001: begin base_o = lane_s[GPR_EBX]; index_o = lane_s[GPR_EDI]; end
        3'b010: begin base_o = lane_s[GPR_EBP]; index_o = lane_s[GPR_ESI]; ss_o = 1'b1; end
        3'b011: begin base_o = lane_s[GPR_EBP]; index_o = lane_s[GPR_EDI]; ss_o = 1'b1; end
        3'b100: base_o = lane_s[GPR_ESI];
        3'b101: base_o = lane_s[GPR_EDI];
        DISP_ONLY_RM16: begin
          if (mod_i == MOD_NODISP) begin
            disp32_s = sext16(disp_i[15:0]);
          end else begin
            base_o = lane_s[GPR_EBP];
            ss_o   = 1'b1;
          end
        end
        default: base_o = lane_s[GPR_EBX];
      endcase
    end else if (rm_i == SIB_RM) begin
      if (sib_i.index != NO_INDEX) begin
        index_o = lane_s[sib_i.index];
        scale_o = sib_i.scale;
      end else begin
        index_o = '0;
        scale_o = 2'b00;
      end
      if ((sib_i.base == DISP_ONLY_RM32) && (mod_i == MOD_NODISP)) begin
        disp32_s = disp_i;
      end else begin
        base_o = lane_s[sib_i.base];
        ss_o   = (sib_i.base == GPR_ESP) || (sib_i.base == GPR_EBP);
      end
    end else if ((rm_i == DISP_ONLY_RM32) && (mod_i == MOD_NODISP)) begin
      disp32_s = disp_i;
    end else begin
      base_o = lane_s[rm_i];
      ss_o   = (rm_i == GPR_EBP);
    end
  end

  assign disp_o = disp32_s[ADDR_W-1:0];

endmodule

// File: rtl/modrm_sib_ea_pipe.sv
// Pipelined ModR/M + SIB effective-address generator. Stage 1 latches selected
// operands; stage 2 sums them, optionally through a registered output stage.
module modrm_sib_ea_pipe
  import x86_addr_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit PIPE_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                addr32,
  input  logic [7:0]          modrm,
  input  logic [7:0]          sib,
  input  logic [31:0]         disp,
  input  logic [8*ADDR_W-1:0] gpr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   ea,
  output logic [2:0]          regnum,
  output logic                rm_is_reg,
  output logic [2:0]          rm_regnum,
  output logic                ss_default
);

  localparam bit                HAS_ADDR32 = (ADDR_W > 16);
  localparam logic [ADDR_W-1:0] MASK16     = ADDR_W'(32'h0000_FFFF);

  modrm_t            modrm_s;
  sib_t              sib_s;
  logic              a32_s;
  logic [ADDR_W-1:0] sel_base_s, sel_index_s, sel_disp_s;
  logic [1:0]        sel_scale_s;
  logic              sel_ss_s;
  logic              accept_s, s1_adv_s;

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_base_q, s1_index_q, s1_disp_q;
  logic [1:0]        s1_scale_q;
  logic              s1_a32_q, s1_isreg_q, s1_ss_q;
  logic [2:0]        s1_reg_q, s1_rm_q;
  logic [ADDR_W-1:0] sum_s, ea_s;

  assign modrm_s = modrm_t'(modrm);
  assign sib_s   = sib_t'(sib);
  // a 16-bit-only build never sees 32-bit addressing
  assign a32_s   = addr32 & HAS_ADDR32;

  modrm_sib_select #(.ADDR_W(ADDR_W)) u_select (
    .addr32_i (a32_s),
    .mod_i    (modrm_s.mod),
    .rm_i     (modrm_s.rm),
    .sib_i    (sib_s),
    .disp_i   (disp),
    .gpr_i    (gpr),
    .base_o   (sel_base_s),
    .index_o  (sel_index_s),
    .scale_o  (sel_scale_s),
    .disp_o   (sel_disp_s),
    .ss_o     (sel_ss_s)
  );

  assign in_ready = !s1_valid_q || s1_adv_s;
  // clear takes priority over a request offered in the same cycle
  assign accept_s = in_valid && in_ready && !clear;

  // Stage-1 occupancy: clear flushes, accept fills, advancing empties
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (clear) begin
      s1_valid_d = 1'b0;
    end else if (accept_s) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage-1 valid flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  // Stage-1 operand capture on accept; held otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_base_q  <= '0;
      s1_index_q <= '0;
      s1_disp_q  <= '0;
      s1_scale_q <= 2'b00;
      s1_a32_q   <= 1'b0;
      s1_isreg_q <= 1'b0;
      s1_ss_q    <= 1'b0;
      s1_reg_q   <= 3'b000;
      s1_rm_q    <= 3'b000;
    end else if (accept_s) begin
      s1_base_q  <= sel_base_s;
      s1_index_q <= sel_index_s;
      s1_disp_q  <= sel_disp_s;
      s1_scale_q <= sel_scale_s;
      s1_a32_q   <= a32_s;
      s1_isreg_q <= (modrm_s.mod == MOD_REG);
      s1_ss_q    <= sel_ss_s;
      s1_reg_q   <= modrm_s.reg_op;
      s1_rm_q    <= modrm_s.rm;
    end
  end

  // Address sum, wrapped to 16 bits for 16-bit addressing
  always_comb begin
    sum_s = s1_base_q + (s1_index_q << s1_scale_q) + s1_disp_q;
    if (s1_a32_q) begin
      ea_s = sum_s;
    end else begin
      ea_s = sum_s & MASK16;
    end
  end

  generate
    if (PIPE_OUT) begin : g_out_reg
      logic              s2_valid_q, s2_valid_d;
      logic [ADDR_W-1:0] s2_ea_q;
      logic [2:0]        s2_reg_q, s2_rm_q;
      logic              s2_isreg_q, s2_ss_q;

      assign s1_adv_s = s1_valid_q && (!s2_valid_q || out_ready);

      // Output-stage occupancy: clear flushes, stage-1 advance fills, consumer drains
      always_comb begin
        s2_valid_d = s2_valid_q;
        if (clear) begin
          s2_valid_d = 1'b0;
        end else if (s1_adv_s) begin
          s2_valid_d = 1'b1;
        end else if (out_ready) begin
          s2_valid_d = 1'b0;
        end else begin
          s2_valid_d = s2_valid_q;
        end
      end

      // Output-stage registers; contents hold while the consumer stalls
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s2_valid_q <= 1'b0;
          s2_ea_q    <= '0;
          s2_reg_q   <= 3'b000;
          s2_rm_q    <= 3'b000;
          s2_isreg_q <= 1'b0;
          s2_ss_q    <= 1'b0;
        end else begin
          s2_valid_q <= s2_valid_d;
          if (s1_adv_s) begin
            s2_ea_q    <= ea_s;
            s2_reg_q   <= s1_reg_q;
            s2_rm_q    <= s1_rm_q;
            s2_isreg_q <= s1_isreg_q;
            s2_ss_q    <= s1_ss_q;
          end
        end
      end

      assign out_valid  = s2_valid_q;
      assign ea         = s2_ea_q;
      assign regnum     = s2_reg_q;
      assign rm_regnum  = s2_rm_q;
      assign rm_is_reg  = s2_isreg_q;
      assign ss_default = s2_ss_q;
    end else begin : g_out_comb
      assign s1_adv_s   = s1_valid_q && out_ready;
      assign out_valid  = s1_valid_q;
      assign ea         = ea_s;
      assign regnum     = s1_reg_q;
      assign rm_regnum  = s1_rm_q;
      assign rm_is_reg  = s1_isreg_q;
      assign ss_default = s1_ss_q;
    end
  endgenerate

endmodule
